// File: rtl/sigma_del.sv
// sigma_del: single-bit sigma-delta modulator (pulse-density DAC stream).
// Ports: a (WIDTH-bit unsigned level), out (registered bit), clk, rst (async, active-low).
// Optional second-order loop enabled by defining SIGMA_DEL_ORDER2_EN;
// default build is the first-order accumulator/carry modulator.
module sigma_del #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic             out,
    input  logic             clk,
    input  logic             rst
);

    logic out_q;
    logic out_d;

    assign out = out_q;

`ifdef SIGMA_DEL_ORDER2_EN

    // IW holds the integrators; XW gives headroom so sums never wrap
    // before saturation is applied.
    localparam int IW = WIDTH + 5;
    localparam int XW = WIDTH + 7;

    logic signed [IW-1:0] i1_q;
    logic signed [IW-1:0] i1_d;
    logic signed [IW-1:0] i2_q;
    logic signed [IW-1:0] i2_d;
    logic signed [XW-1:0] lim_p;
    logic signed [XW-1:0] lim_n;
    logic signed [XW-1:0] fb_x;
    logic signed [XW-1:0] a_x;
    logic signed [XW-1:0] e1_x;
    logic signed [XW-1:0] e2_x;

    // +/-(2^(WIDTH+3)-1)
    assign lim_p = $signed({{(XW-WIDTH-3){1'b0}}, {(WIDTH+3){1'b1}}});
    assign lim_n = -lim_p;

    function automatic logic signed [IW-1:0] sat(
        input logic signed [XW-1:0] v,
        input logic signed [XW-1:0] hi,
        input logic signed [XW-1:0] lo
    );
        logic signed [XW-1:0] r;
        r = v;
        if (v > hi) r = hi;
        if (v < lo) r = lo;
        return r[IW-1:0];
    endfunction

    always_comb begin
        fb_x = '0;
        if (out_q) fb_x = $signed({{(XW-WIDTH-1){1'b0}}, 1'b1, {WIDTH{1'b0}}});
        a_x  = $signed({{(XW-WIDTH){1'b0}}, a});
        e1_x = $signed({{(XW-IW){i1_q[IW-1]}}, i1_q}) + a_x - fb_x;
        i1_d = sat(e1_x, lim_p, lim_n);
        e2_x = $signed({{(XW-IW){i2_q[IW-1]}}, i2_q})
             + $signed({{(XW-IW){i1_d[IW-1]}}, i1_d}) - fb_x;
        i2_d = sat(e2_x, lim_p, lim_n);
        // Strictly positive: non-negative and non-zero
        out_d = !i2_d[IW-1] && (i2_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i1_q  <= '0;
            i2_q  <= '0;
            out_q <= 1'b0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            out_q <= out_d;
        end
    end

`else

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH:0]   sum;

    // Carry out of the wrapping accumulator is the output bit
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, a};
        acc_d = sum[WIDTH-1:0];
        out_d = sum[WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            out_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

`endif

endmodule

// File: tb/tb_sigma_del.sv
// tb_sigma_del: scoreboard bench for sigma_del (WIDTH=8 and WIDTH=32 instances).
// Stimulus pushes expected bits per edge; a negedge monitor pops and compares.
module tb_sigma_del;

    logic        clk = 1'b0;
    logic [7:0]  a8;
    logic        o8;
    logic        rst8;
    logic [31:0] a32;
    logic        o32;
    logic        rst32;

    int checks = 0;
    int errors = 0;
    int ones8  = 0;
    bit q8[$];
    bit q32[$];

    always #5 clk = ~clk;

    sigma_del #(.WIDTH(8)) dut8 (
        .a   (a8),
        .out (o8),
        .clk (clk),
        .rst (rst8)
    );

    sigma_del #(.WIDTH(32)) dut32 (
        .a   (a32),
        .out (o32),
        .clk (clk),
        .rst (rst32)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per edge, compared at the following negedge
    always @(negedge clk) begin
        bit e;
        if (q8.size() > 0) begin
            e = q8.pop_front();
            chk("out8", 64'(o8), 64'(e));
            if (o8 === 1'b1) ones8++;
        end
        if (q32.size() > 0) begin
            e = q32.pop_front();
            chk("out32", 64'(o32), 64'(e));
        end
    end

    task automatic step8(input bit exp);
        @(posedge clk);
        q8.push_back(exp);
        #1;
    endtask

    task automatic step32(input bit exp);
        @(posedge clk);
        q32.push_back(exp);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        a8    = '0;
        a32   = '0;
        rst8  = 1'b0;
        rst32 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out8", 64'(o8), 64'd0);
        chk("rst_out32", 64'(o32), 64'd0);

`ifdef SIGMA_DEL_ORDER2_EN
        begin
            int n1 = 0;
            int bad = 0;
            rst8 = 1'b1;
            a8   = 8'd64;
            for (int k = 0; k < 4096; k++) begin
                @(posedge clk);
                #1;
                if (o8 === 1'b1) n1++;
                if (dut8.i1_q > 2047 || dut8.i1_q < -2047) bad++;
                if (dut8.i2_q > 2047 || dut8.i2_q < -2047) bad++;
            end
            chk("o2_ones_lo", 64'(n1 >= 1022), 64'd1);
            chk("o2_ones_hi", 64'(n1 <= 1026), 64'd1);
            chk("o2_sat", 64'(bad), 64'd0);
            rst8 = 1'b0;
            #1;
            chk("o2_rst", 64'(o8), 64'd0);
            a8 = 8'd0;
            @(negedge clk);
            rst8 = 1'b1;
            for (int k = 0; k < 200; k++) step8(1'b0);
            settle();
        end
`else
        // a=3 from reset: ones exactly after edges 86, 171, 256
        rst8  = 1'b1;
        a8    = 8'd3;
        ones8 = 0;
        for (int k = 1; k <= 256; k++)
            step8(k == 86 || k == 171 || k == 256);
        settle();
        chk("ones_a3", 64'(ones8), 64'd3);

        // a=128 alternates 0,1,0,1 (acc is 0 here)
        a8 = 8'd128;
        for (int k = 1; k <= 8; k++) step8(k % 2 == 0);
        settle();
        chk("pre_rst_out", 64'(o8), 64'd1);

        // Asynchronous reset between edges
        rst8 = 1'b0;
        #1;
        chk("async_rst", 64'(o8), 64'd0);
        step8(1'b0);
        step8(1'b0);
        rst8 = 1'b1;
        for (int k = 1; k <= 4; k++) step8(k % 2 == 0);

        // a=0 long run, then a=255: zero on edge 1 only
        a8 = 8'd0;
        for (int k = 0; k < 1000; k++) step8(1'b0);
        settle();
        ones8 = 0;
        a8 = 8'd255;
        for (int k = 1; k <= 256; k++) step8(k != 1);
        settle();
        chk("ones_a255", 64'(ones8), 64'd255);

        // Level change keeps acc: 128 -> acc 128, then 192 carries
        a8 = 8'd128;
        step8(1'b0);
        a8 = 8'd192;
        step8(1'b1);
        a8 = 8'd0;
        step8(1'b0);
        step8(1'b0);
        settle();

        // WIDTH=32, a=3 for 10000 edges: no ones, acc=30000
        a32   = 32'd3;
        rst32 = 1'b1;
        for (int k = 0; k < 10000; k++) step32(1'b0);
        chk("acc32", 64'(dut32.acc_q), 64'd30000);
        settle();
`endif

        chk("q_drained", 64'(q8.size() + q32.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
